// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the EX-stage branch resolver.
// Optional feature macro used by the top level: BRU_PERF_CNT_EN.
package bru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        BRU_IDLE     = 1'b0,
        BRU_REDIRECT = 1'b1
    } bru_state_e;

    typedef logic [1:0] bht_ctr_t;

    // Weak not-taken: one taken outcome flips the prediction.
    localparam bht_ctr_t BHT_INIT = 2'b01;

    // funct3 010/011 have no branch meaning and must not train or count.
    function automatic logic f3_is_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    // Map funct3 plus comparator flags onto the branch outcome.
    function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
        logic taken;
        taken = 1'b0;
        case (f3)
            F3_BEQ:           taken = eq;
            F3_BNE:           taken = !eq;
            F3_BLT, F3_BLTU:  taken = lt;
            F3_BGE, F3_BGEU:  taken = !lt;
            default:          taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// 2-bit saturating branch history table: one combinational read port for
// the IF lookup and one synchronous update port from EX resolution.
module bru_bht
    import bru_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bht_ctr_t         o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_ctr_t ctr [ENTRIES];
    bht_ctr_t wr_cur;
    bht_ctr_t wr_next;

    // The read returns the stored value, so a same-cycle update is not visible.
    assign o_rd_ctr = ctr[i_rd_idx];
    assign wr_cur   = ctr[i_wr_idx];

    // Saturating increment on taken, decrement on not-taken.
    always_comb begin
        wr_next = wr_cur;
        if (i_wr_taken) begin
            if (wr_cur != 2'b11) wr_next = wr_cur + 2'b01;
        end else begin
            if (wr_cur != 2'b00) wr_next = wr_cur - 2'b01;
        end
    end

    // Counter storage; every entry returns to weak not-taken on reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= BHT_INIT;
        end else if (i_wr_en) begin
            ctr[i_wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch/jump resolver: selects the outcome from comparator flags,
// detects mispredictions, issues a registered redirect/flush and trains the
// BHT read by IF. Define BRU_PERF_CNT_EN to build the performance counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int XLEN  = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stall,
    input  logic            i_valid_ex,
    input  logic            i_is_br,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic [2:0]      i_funct3,
    input  logic            i_br_eq,
    input  logic            i_br_lt,
    output logic            o_br_unsigned,
    input  logic [XLEN-1:0] i_pc_ex,
    input  logic [XLEN-1:0] i_target_ex,
    input  logic            i_pred_taken_ex,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_if_pred_taken,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_flush,
    output logic [31:0]     o_br_count,
    output logic [31:0]     o_mispred_count
);

    bru_state_e      state;
    logic            sel_jalr;
    logic            sel_jal;
    logic            sel_br;
    logic            br_legal;
    logic            resolve;
    logic            act_taken;
    logic            mispredict;
    logic            bht_train;
    logic [XLEN-1:0] fix_pc;
    bht_ctr_t        if_ctr;
    logic            unused_bits;

    // BLTU/BGEU are the funct3 codes with bit 1 set.
    assign o_br_unsigned = i_funct3[1];

    // A malformed decode with several type bits resolves as jalr > jal > br.
    assign sel_jalr = i_is_jalr;
    assign sel_jal  = i_is_jal & ~i_is_jalr;
    assign sel_br   = i_is_br & ~i_is_jal & ~i_is_jalr;
    assign br_legal = sel_br & f3_is_legal(i_funct3);

    // Instructions arriving while a redirect is pending are wrong-path.
    assign resolve = i_valid_ex & ~i_stall & (state == BRU_IDLE);

    // Jumps always take; branches follow funct3; anything else falls through.
    always_comb begin
        act_taken = 1'b0;
        if (sel_jalr || sel_jal) begin
            act_taken = 1'b1;
        end else if (br_legal) begin
            act_taken = f3_taken(i_funct3, i_br_eq, i_br_lt);
        end
    end

    // JALR targets are never predicted by the front end, so it always redirects.
    assign mispredict = sel_jalr | (act_taken != i_pred_taken_ex);
    assign fix_pc     = act_taken ? i_target_ex : i_pc_ex + XLEN'(4);
    assign bht_train  = resolve & br_legal;

    bru_bht #(
        .IDX_W (IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rd_idx   (i_if_pc[IDX_W+1:2]),
        .o_rd_ctr   (if_ctr),
        .i_wr_en    (bht_train),
        .i_wr_idx   (i_pc_ex[IDX_W+1:2]),
        .i_wr_taken (act_taken)
    );

    assign o_if_pred_taken = if_ctr[1];
    assign unused_bits     = ^{if_ctr[0], i_if_pc[XLEN-1:IDX_W+2], i_if_pc[1:0]};

    // Redirect FSM: raise the redirect the cycle after a mispredict and hold it until the pipe moves.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= BRU_IDLE;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
        end else begin
            case (state)
                BRU_IDLE: begin
                    if (resolve && mispredict) begin
                        state         <= BRU_REDIRECT;
                        o_redirect    <= 1'b1;
                        o_redirect_pc <= fix_pc;
                    end
                end
                BRU_REDIRECT: begin
                    if (!i_stall) begin
                        state      <= BRU_IDLE;
                        o_redirect <= 1'b0;
                    end
                end
                default: begin
                    state      <= BRU_IDLE;
                    o_redirect <= 1'b0;
                end
            endcase
        end
    end

    assign o_flush = o_redirect;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] br_count_q;
    logic [31:0] mispred_count_q;

    // Saturating event counters for resolved branches and issued redirects.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (bht_train && (br_count_q != 32'hFFFF_FFFF)) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (resolve && mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign o_br_count      = br_count_q;
    assign o_mispred_count = mispred_count_q;
`else
    assign o_br_count      = 32'd0;
    assign o_mispred_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Counter expectations follow BRU_PERF_CNT_EN.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        valid_ex;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic        br_eq;
    logic        br_lt;
    logic        br_unsigned;
    logic [31:0] pc_ex;
    logic [31:0] target_ex;
    logic        pred_taken_ex;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int errors = 0;
    int checks = 0;

    branch_resolve_unit #(
        .IDX_W (6),
        .XLEN  (32)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_stall         (stall),
        .i_valid_ex      (valid_ex),
        .i_is_br         (is_br),
        .i_is_jal        (is_jal),
        .i_is_jalr       (is_jalr),
        .i_funct3        (funct3),
        .i_br_eq         (br_eq),
        .i_br_lt         (br_lt),
        .o_br_unsigned   (br_unsigned),
        .i_pc_ex         (pc_ex),
        .i_target_ex     (target_ex),
        .i_pred_taken_ex (pred_taken_ex),
        .i_if_pc         (if_pc),
        .o_if_pred_taken (if_pred_taken),
        .o_redirect      (redirect),
        .o_redirect_pc   (redirect_pc),
        .o_flush         (flush),
        .o_br_count      (br_count),
        .o_mispred_count (mispred_count)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic br, input logic jal, input logic jalr,
                                 input logic [2:0] f3, input logic eq, input logic lt,
                                 input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
        valid_ex      = v;
        is_br         = br;
        is_jal        = jal;
        is_jalr       = jalr;
        funct3        = f3;
        br_eq         = eq;
        br_lt         = lt;
        pred_taken_ex = pred;
        pc_ex         = pc;
        target_ex     = tgt;
    endtask

    task automatic idle;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic peekPred(input string tag, input logic [31:0] pc, input logic expected);
        if_pc = pc;
        #1;
        checkOutput(tag, {31'd0, if_pred_taken}, {31'd0, expected});
    endtask

    initial begin
        logic [31:0] exp_br_cnt;
        logic [31:0] exp_mp_cnt;

        reset = 1'b1;
        stall = 1'b0;
        if_pc = 32'h0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("reset_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("reset_flush", {31'd0, flush}, 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'h0);
        checkOutput("reset_br_count", br_count, 32'd0);
        checkOutput("reset_mispred_count", mispred_count, 32'd0);
        peekPred("reset_bht_0x100", 32'h100, 1'b0);
        reset = 1'b0;
        tick();

        $display("[TB] BEQ taken, predicted not-taken");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h140);
        peekPred("beq_lookup_no_bypass", 32'h100, 1'b0);
        checkOutput("beq_signed_mode", {31'd0, br_unsigned}, 32'd0);
        tick();
        idle();
        checkOutput("beq_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("beq_flush", {31'd0, flush}, 32'd1);
        checkOutput("beq_redirect_pc", redirect_pc, 32'h140);
        peekPred("beq_bht_trained", 32'h100, 1'b1);
        tick();
        checkOutput("beq_redirect_drop", {31'd0, redirect}, 32'd0);

        $display("[TB] BLTU not-taken twice, then taken twice");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 32'h104, 32'h180);
        #1;
        checkOutput("bltu_unsigned_mode", {31'd0, br_unsigned}, 32'd1);
        tick();
        checkOutput("bltu_nt1_no_redirect", {31'd0, redirect}, 32'd0);
        tick();
        checkOutput("bltu_nt2_no_redirect", {31'd0, redirect}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 32'h104, 32'h180);
        tick();
        checkOutput("bltu_t1_no_redirect", {31'd0, redirect}, 32'd0);
        peekPred("bltu_saturated_low", 32'h104, 1'b0);
        tick();
        idle();
        peekPred("bltu_back_to_taken", 32'h104, 1'b1);

        $display("[TB] JALR redirect, wrong-path BEQ ignored");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h108, 32'h2000);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h10C, 32'h500);
        checkOutput("jalr_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("jalr_redirect_pc", redirect_pc, 32'h2000);
        tick();
        idle();
        checkOutput("wrongpath_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("wrongpath_redirect_pc", redirect_pc, 32'h2000);
        peekPred("wrongpath_bht_untouched", 32'h10C, 1'b0);
        peekPred("jalr_no_train", 32'h108, 1'b0);

        $display("[TB] JAL and decode priority");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'h120, 32'h600);
        tick();
        idle();
        checkOutput("jal_pred_ok", {31'd0, redirect}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h124, 32'h640);
        tick();
        idle();
        checkOutput("jal_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("jal_redirect_pc", redirect_pc, 32'h640);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'h128, 32'h700);
        tick();
        idle();
        checkOutput("prio_jalr_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("prio_jalr_pc", redirect_pc, 32'h700);
        tick();

        $display("[TB] stall behaviour");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'h114, 32'h240);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        idle();
        checkOutput("idle_stall_no_redirect", {31'd0, redirect}, 32'd0);
        peekPred("idle_stall_no_train", 32'h114, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'h110, 32'h300);
        tick();
        idle();
        stall = 1'b1;
        checkOutput("stall_redirect_c1", {31'd0, redirect}, 32'd1);
        checkOutput("stall_redirect_pc", redirect_pc, 32'h300);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall_redirect_c%0d", i + 2), {31'd0, redirect}, 32'd1);
        end
        stall = 1'b0;
        tick();
        checkOutput("stall_redirect_release", {31'd0, redirect}, 32'd0);

        $display("[TB] reset during redirect");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 32'h118, 32'h400);
        tick();
        idle();
        checkOutput("pre_reset_redirect", {31'd0, redirect}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("async_reset_flush", {31'd0, flush}, 32'd0);
        checkOutput("async_reset_pc", redirect_pc, 32'h0);
        peekPred("reset_bht_0x100_again", 32'h100, 1'b0);
        peekPred("reset_bht_0x104", 32'h104, 1'b0);
        checkOutput("async_reset_br_count", br_count, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] counter sequence");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 32'h130, 32'h700);
        tick();
        checkOutput("cnt_beq_ok", {31'd0, redirect}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 32'h134, 32'h700);
        tick();
        checkOutput("cnt_bne_ok", {31'd0, redirect}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0, 1'b1, 1'b0, 32'h138, 32'h800);
        tick();
        idle();
        checkOutput("cnt_blt_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("cnt_blt_pc", redirect_pc, 32'h800);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 32'h13C, 32'h800);
        tick();
        checkOutput("cnt_bgeu_ok", {31'd0, redirect}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h900);
        tick();
        idle();
        checkOutput("cnt_bltu_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("cnt_bltu_pc_wrap", redirect_pc, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 32'h140, 32'h900);
        tick();
        idle();
        checkOutput("cnt_illegal_no_redirect", {31'd0, redirect}, 32'd0);
        tick();

`ifdef BRU_PERF_CNT_EN
        exp_br_cnt = 32'd5;
        exp_mp_cnt = 32'd2;
`else
        exp_br_cnt = 32'd0;
        exp_mp_cnt = 32'd0;
`endif
        checkOutput("br_count", br_count, exp_br_cnt);
        checkOutput("mispred_count", mispred_count, exp_mp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
